// File: rtl/axi4_lite_slave_write_ctrl_if.sv
// AXI4-Lite slave write-channel bundle: AW, W and B channels.
// slave modport faces the write controller, master modport faces the bus driver.
// Ports: awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready.
interface axi4_lite_slave_write_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4_lite_slave_write_ctrl.sv
// Purpose: pairs AXI4-Lite AW and W beats (either order), strobes the register bank once, returns B.
// Latency: AW+W accepted in cycle N -> wr_en in N+1 -> bvalid from N+2; 3 cycles/transfer best case.
// Backpressure: one transaction in flight; awready/wready stay low until the B handshake completes.
// Ports: aclk, aresetn (sync, active-low); s_axi (AW/W/B channels, slave modport);
//        wr_en/wr_addr/wr_data/wr_strb/wr_prot to the register bank; wr_err from the bank.
// Build option: AXI4_LITE_SLAVE_WRITE_ALIGN_CHECK_EN makes unaligned addresses a decode error.
module axi4_lite_slave_write_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  axi4_lite_slave_write_ctrl_if.slave s_axi,
  output logic                       wr_en,
  output logic [ADDRESS_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH/8-1:0]    wr_strb,
  output logic [2:0]                 wr_prot,
  input  logic                       wr_err
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int LIMIT_W  = ADDRESS_WIDTH + 1;
  // One extra bit so the limit never wraps, whatever the address width.
  localparam logic [LIMIT_W-1:0] ADDR_LIMIT = LIMIT_W'(NUM_REGS * STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WAIT_W, WAIT_AW, WRITE, RESP} state_t;

  state_t                     state, state_next;
  logic                       awready_d, wready_d;
  logic                       aw_hs, w_hs;
  logic                       dec_err;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [STRB_W-1:0]          strb_q;
  logic [2:0]                 prot_q;
  logic [1:0]                 bresp_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    case (state)
      IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (s_axi.awvalid && s_axi.wvalid) state_next = WRITE;
        else if (s_axi.awvalid)            state_next = WAIT_W;
        else if (s_axi.wvalid)             state_next = WAIT_AW;
      end
      WAIT_W: begin
        wready_d = 1'b1;
        if (s_axi.wvalid) state_next = WRITE;
      end
      WAIT_AW: begin
        awready_d = 1'b1;
        if (s_axi.awvalid) state_next = WRITE;
      end
      WRITE:   state_next = RESP;
      RESP:    if (s_axi.bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Readies are gated by reset so nothing is accepted (or captured) while reset is held.
  assign s_axi.awready = aresetn && awready_d;
  assign s_axi.wready  = aresetn && wready_d;
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;

  always_comb begin
    dec_err = ({1'b0, addr_q} >= ADDR_LIMIT);
`ifdef AXI4_LITE_SLAVE_WRITE_ALIGN_CHECK_EN
    if (addr_q[$clog2(STRB_W)-1:0] != '0) dec_err = 1'b1;
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        addr_q <= s_axi.awaddr;
        prot_q <= s_axi.awprot;
      end
      if (w_hs) begin
        data_q <= s_axi.wdata;
        strb_q <= s_axi.wstrb;
      end
      // Bank error is only meaningful in the strobe cycle; latch the response there.
      if (state == WRITE) bresp_q <= (dec_err || wr_err) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Every output reads 0 while reset is asserted, including before the first reset edge.
  assign s_axi.bvalid = aresetn && (state == RESP);
  assign s_axi.bresp  = aresetn ? bresp_q : 2'b00;
  assign wr_en        = aresetn && (state == WRITE) && !dec_err;
  assign wr_addr      = aresetn ? addr_q : '0;
  assign wr_data      = aresetn ? data_q : '0;
  assign wr_strb      = aresetn ? strb_q : '0;
  assign wr_prot      = aresetn ? prot_q : '0;
endmodule

// File: tb/tb_axi4_lite_slave_write_ctrl.sv
module tb_axi4_lite_slave_write_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [2:0]    wr_prot;
  logic          wr_err = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  axi4_lite_slave_write_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_slave_write_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_prot (wr_prot),
    .wr_err  (wr_err)
  );

  typedef struct {
    int            n_wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    logic [1:0]    bresp;
    int            wren_cyc;
    int            bvalid_cyc;
    int            viol;
    int            ncyc;
    bit            timeout;
  } obs_t;

  // Reference: an address is rejected if it lies beyond the register file
  // (or, with the alignment option, is not a multiple of the bus width).
  function automatic bit ref_dec_err(input logic [AW-1:0] a);
    bit e;
    e = (a >= 32'(NR * SW));
`ifdef AXI4_LITE_SLAVE_WRITE_ALIGN_CHECK_EN
    if ((a % 32'(SW)) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [1:0] ref_bresp(input logic [AW-1:0] a, input bit err);
    return (ref_dec_err(a) || err) ? 2'b10 : 2'b00;
  endfunction

  // Drives one transaction (AW and W offered after independent delays, bready after
  // b_dly cycles of bvalid) and records what the bank and B channel saw.
  // Cycle t=0 is the first cycle of the call; outputs sampled 1ns after each edge.
  task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] strb, input logic [2:0] prot, input bit err,
                         input int aw_dly, input int w_dly, input int b_dly, output obs_t o);
    bit aw_done, w_done, done, b_seen, aw_fire, w_fire;
    int b_cnt;
    aw_done = 0; w_done = 0; done = 0; b_seen = 0; b_cnt = 0;
    o.n_wren = 0; o.addr = '0; o.data = '0; o.strb = '0; o.prot = '0; o.bresp = '0;
    o.wren_cyc = -1; o.bvalid_cyc = -1; o.viol = 0; o.ncyc = 0; o.timeout = 0;
    bus.awaddr = addr; bus.awprot = prot; bus.wdata = data; bus.wstrb = strb;
    wr_err = err;
    for (int t = 0; t < 64 && !done; t++) begin
      bus.awvalid = !aw_done && (t >= aw_dly);
      bus.wvalid  = !w_done && (t >= w_dly);
      bus.bready  = bus.bvalid && (b_cnt >= b_dly);
      if (wr_en) begin
        o.n_wren++; o.wren_cyc = t;
        o.addr = wr_addr; o.data = wr_data; o.strb = wr_strb; o.prot = wr_prot;
      end
      if (aw_done && !w_done && (bus.awready !== 1'b0 || bus.wready !== 1'b1)) o.viol++;
      if (!aw_done && w_done && (bus.awready !== 1'b1 || bus.wready !== 1'b0)) o.viol++;
      if (aw_done && w_done && (bus.awready !== 1'b0 || bus.wready !== 1'b0)) o.viol++;
      if (bus.bvalid) begin
        if (!(aw_done && w_done)) o.viol++;
        if (!b_seen) begin
          b_seen = 1; o.bresp = bus.bresp; o.bvalid_cyc = t;
        end else if (bus.bresp !== o.bresp) o.viol++;
        if (bus.bready) done = 1;
        b_cnt++;
      end
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(posedge aclk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      o.ncyc = t + 1;
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; wr_err = 0;
    o.timeout = !done;
  endtask

  task automatic test_reset;
    aresetn = 0;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    bus.awaddr = 32'h4; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.awprot = 3'h7;
    repeat (3) @(posedge aclk);
    #1;
    n_cmp++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL rst_awready got %b want 0", bus.awready); end
    n_cmp++; if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready got %b want 0", bus.wready); end
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid got %b want 0", bus.bvalid); end
    n_cmp++; if (bus.bresp !== 2'b00) begin n_fail++; $display("FAIL rst_bresp got %b want 00", bus.bresp); end
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
    n_cmp++; if ({wr_addr, wr_data, wr_strb, wr_prot} !== '0) begin
      n_fail++; $display("FAIL rst_wr_regs got %h/%h/%h/%h want 0", wr_addr, wr_data, wr_strb, wr_prot);
    end
    bus.awvalid = 0; bus.wvalid = 0;
    aresetn = 1;
    @(posedge aclk); #1;
    n_cmp++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      n_fail++; $display("FAIL rst_idle_ready got aw=%b w=%b want 1/1", bus.awready, bus.wready);
    end
  endtask

  task automatic test_simultaneous;
    obs_t o;
    run_txn(32'h4, 32'hDEAD_BEEF, 4'hF, 3'h0, 1'b0, 0, 0, 0, o);
    n_cmp++; if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL sim_timeout got %b want 0", o.timeout); end
    n_cmp++; if (o.n_wren != 1) begin n_fail++; $display("FAIL sim_wren_count got %0d want 1", o.n_wren); end
    n_cmp++; if (o.wren_cyc != 1) begin n_fail++; $display("FAIL sim_wren_cycle got %0d want 1", o.wren_cyc); end
    n_cmp++; if (o.addr !== 32'h4) begin n_fail++; $display("FAIL sim_wr_addr got %h want 00000004", o.addr); end
    n_cmp++; if (o.data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sim_wr_data got %h want deadbeef", o.data); end
    n_cmp++; if (o.strb !== 4'hF) begin n_fail++; $display("FAIL sim_wr_strb got %h want f", o.strb); end
    n_cmp++; if (o.bvalid_cyc != 2) begin n_fail++; $display("FAIL sim_bvalid_cycle got %0d want 2", o.bvalid_cyc); end
    n_cmp++; if (o.bresp !== 2'b00) begin n_fail++; $display("FAIL sim_bresp got %b want 00", o.bresp); end
  endtask

  task automatic test_split_order;
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      // k=0: W first, AW three cycles later; k=1: the reverse.
      run_txn(32'h10 + 32'(k * 4), 32'h1234_5678 + 32'(k), 4'hA, 3'h3, 1'b0,
              (k == 0) ? 3 : 0, (k == 0) ? 0 : 3, 0, o);
      n_cmp++; if (o.viol != 0) begin n_fail++; $display("FAIL split%0d_ready_viol got %0d want 0", k, o.viol); end
      n_cmp++; if (o.n_wren != 1) begin n_fail++; $display("FAIL split%0d_wren_count got %0d want 1", k, o.n_wren); end
      n_cmp++; if (o.wren_cyc != 4) begin n_fail++; $display("FAIL split%0d_wren_cycle got %0d want 4", k, o.wren_cyc); end
      n_cmp++; if (o.data !== 32'h1234_5678 + 32'(k)) begin n_fail++; $display("FAIL split%0d_wr_data got %h", k, o.data); end
      n_cmp++; if (o.bresp !== 2'b00 || o.timeout) begin
        n_fail++; $display("FAIL split%0d_bresp got %b (timeout %b) want 00", k, o.bresp, o.timeout);
      end
    end
  endtask

  task automatic test_decode_error;
    obs_t o;
    run_txn(32'h40, 32'hCAFE_F00D, 4'hF, 3'h0, 1'b0, 0, 0, 0, o);
    n_cmp++; if (o.n_wren != 0) begin n_fail++; $display("FAIL dec_wren_count got %0d want 0", o.n_wren); end
    n_cmp++; if (o.bresp !== 2'b10 || o.timeout) begin
      n_fail++; $display("FAIL dec_bresp got %b (timeout %b) want 10", o.bresp, o.timeout);
    end
  endtask

  task automatic test_backpressure;
    bus.awaddr = 32'h8; bus.wdata = 32'h1111_2222; bus.wstrb = 4'hF; bus.awprot = 3'h2;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    @(posedge aclk); #1;
    // A second transaction is offered straight away and held through the stalled response.
    bus.awaddr = 32'hC; bus.wdata = 32'h3333_4444; bus.awprot = 3'h5;
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 32'h8) begin
      n_fail++; $display("FAIL bp_first_write got en=%b addr=%h want 1/00000008", wr_en, wr_addr);
    end
    @(posedge aclk); #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.awready !== 1'b0 ||
          bus.wready !== 1'b0 || wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got bvalid=%b bresp=%b awready=%b wready=%b wr_en=%b want 1/00/0/0/0",
                 i, bus.bvalid, bus.bresp, bus.awready, bus.wready, wr_en);
      end
      @(posedge aclk); #1;
    end
    bus.bready = 1;
    @(posedge aclk); #1;
    bus.bready = 0;
    n_cmp++; if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      n_fail++; $display("FAIL bp_after_b got bvalid=%b awready=%b wready=%b want 0/1/1", bus.bvalid, bus.awready, bus.wready);
    end
    @(posedge aclk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 32'hC || wr_data !== 32'h3333_4444 || wr_prot !== 3'h5) begin
      n_fail++; $display("FAIL bp_second_write got en=%b addr=%h data=%h prot=%h", wr_en, wr_addr, wr_data, wr_prot);
    end
    @(posedge aclk); #1;
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      n_fail++; $display("FAIL bp_second_b got bvalid=%b bresp=%b want 1/00", bus.bvalid, bus.bresp);
    end
    bus.bready = 1;
    @(posedge aclk); #1;
    bus.bready = 0;
  endtask

  task automatic test_wr_err;
    obs_t o;
    run_txn(32'hC, 32'h0BAD_0BAD, 4'h3, 3'h1, 1'b1, 0, 1, 2, o);
    n_cmp++; if (o.n_wren != 1) begin n_fail++; $display("FAIL err_wren_count got %0d want 1", o.n_wren); end
    n_cmp++; if (o.bresp !== 2'b10 || o.timeout) begin
      n_fail++; $display("FAIL err_bresp got %b (timeout %b) want 10", o.bresp, o.timeout);
    end
  endtask

  task automatic test_reset_in_resp;
    bus.awaddr = 32'h10; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF; bus.awprot = 3'h0;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    @(posedge aclk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    @(posedge aclk); #1;
    n_cmp++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL rresp_bvalid_before got %b want 1", bus.bvalid); end
    aresetn = 0;
    @(posedge aclk); #1;
    n_cmp++; if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL rresp_in_reset got bvalid=%b awready=%b wr_en=%b want 0/0/0", bus.bvalid, bus.awready, wr_en);
    end
    aresetn = 1;
    @(posedge aclk); #1;
    n_cmp++; if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      n_fail++; $display("FAIL rresp_idle got bvalid=%b awready=%b wready=%b want 0/1/1", bus.bvalid, bus.awready, bus.wready);
    end
  endtask

  task automatic test_unaligned_and_zero_strb;
    obs_t o;
    run_txn(32'h6, 32'h7777_8888, 4'hF, 3'h0, 1'b0, 0, 0, 0, o);
`ifdef AXI4_LITE_SLAVE_WRITE_ALIGN_CHECK_EN
    n_cmp++; if (o.n_wren != 0 || o.bresp !== 2'b10) begin
      n_fail++; $display("FAIL unaligned got wren=%0d bresp=%b want 0/10", o.n_wren, o.bresp);
    end
`else
    n_cmp++; if (o.n_wren != 1 || o.bresp !== 2'b00 || o.addr !== 32'h6) begin
      n_fail++; $display("FAIL unaligned got wren=%0d bresp=%b addr=%h want 1/00/00000006", o.n_wren, o.bresp, o.addr);
    end
`endif
    run_txn(32'h20, 32'h9999_0000, 4'h0, 3'h0, 1'b0, 0, 0, 0, o);
    n_cmp++; if (o.n_wren != 1 || o.bresp !== 2'b00 || o.strb !== 4'h0) begin
      n_fail++; $display("FAIL zero_strb got wren=%0d bresp=%b strb=%h want 1/00/0", o.n_wren, o.bresp, o.strb);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    for (int k = 0; k < 4; k++) begin
      run_txn(32'(k * 4), 32'($urandom), 4'hF, 3'h0, 1'b0, 0, 0, 0, o);
      n_cmp++; if (o.ncyc != 3 || o.n_wren != 1 || o.timeout) begin
        n_fail++; $display("FAIL b2b%0d got cycles=%0d wren=%0d timeout=%b want 3/1/0", k, o.ncyc, o.n_wren, o.timeout);
      end
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [2:0]    p;
    bit e;
    int awd, wd, bd, first, exp_wren;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, NR - 1) * SW);
        2:       a = 32'($urandom_range(0, NR * SW - 1));
        default: a = 32'($urandom_range(NR * SW, 4 * NR * SW));
      endcase
      d = 32'($urandom); s = 4'($urandom); p = 3'($urandom);
      e = ($urandom_range(0, 3) == 0);
      awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      run_txn(a, d, s, p, e, awd, wd, bd, o);
      first = (awd > wd) ? awd : wd;
      exp_wren = ref_dec_err(a) ? 0 : 1;
      n_cmp++; if (o.timeout || o.viol != 0) begin
        n_fail++; $display("FAIL rnd%0d_protocol got timeout=%b viol=%0d want 0/0", n, o.timeout, o.viol);
      end
      n_cmp++; if (o.n_wren != exp_wren) begin
        n_fail++; $display("FAIL rnd%0d_wren got %0d want %0d (addr %h)", n, o.n_wren, exp_wren, a);
      end
      n_cmp++; if (o.bresp !== ref_bresp(a, e)) begin
        n_fail++; $display("FAIL rnd%0d_bresp got %b want %b (addr %h err %b)", n, o.bresp, ref_bresp(a, e), a, e);
      end
      n_cmp++; if (o.bvalid_cyc != first + 2 || o.ncyc != first + 3 + bd) begin
        n_fail++; $display("FAIL rnd%0d_timing got bvalid@%0d end@%0d want %0d/%0d", n, o.bvalid_cyc, o.ncyc, first + 2, first + 3 + bd);
      end
      if (exp_wren == 1) begin
        n_cmp++; if (o.addr !== a || o.data !== d || o.strb !== s || o.prot !== p || o.wren_cyc != first + 1) begin
          n_fail++; $display("FAIL rnd%0d_bank got %h/%h/%h/%h@%0d want %h/%h/%h/%h@%0d",
                             n, o.addr, o.data, o.strb, o.prot, o.wren_cyc, a, d, s, p, first + 1);
        end
      end
    end
  endtask

  initial begin
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
    bus.awaddr = '0; bus.awprot = '0; bus.wdata = '0; bus.wstrb = '0;
    test_reset();
    test_simultaneous();
    test_split_order();
    test_decode_error();
    test_backpressure();
    test_wr_err();
    test_reset_in_resp();
    test_unaligned_and_zero_strb();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
